// File: rtl/fir_channel_scheduler.sv
// Round-robin scheduler sharing one FIR core across NUM_CH channels.
// A tag FIFO pairs each filter output with the channel that produced its input.
module fir_channel_scheduler #(
  parameter int NUM_CH    = 4,
  parameter int CH_W      = 2,
  parameter int DIN_W     = 32,
  parameter int DOUT_W    = 96,
  parameter int TAG_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         ch_req,
  input  logic [NUM_CH*DIN_W-1:0]   ch_data,
  output logic [NUM_CH-1:0]         ch_ack,
  output logic [DIN_W-1:0]          filt_sink_data,
  output logic                      filt_sink_valid,
  output logic [1:0]                filt_sink_error,
  input  logic [DOUT_W-1:0]         filt_source_data,
  input  logic                      filt_source_valid,
  input  logic [1:0]                filt_source_error,
  output logic [DOUT_W-1:0]         out_data,
  output logic [CH_W-1:0]           out_ch,
  output logic                      out_valid,
  output logic                      busy,
  output logic [1:0]                err
);

  localparam int AW = $clog2(TAG_DEPTH);
  localparam logic [AW:0]         FULL_CNT = (AW+1)'(TAG_DEPTH);
  localparam logic [CH_W:0]       NUM_CH_W = (CH_W+1)'(NUM_CH);
  localparam logic [NUM_CH-1:0]   ONE_HOT0 = {{(NUM_CH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     rr_q, rr_d;
  logic                last_vld_q, last_vld_d;
  logic [CH_W-1:0]     last_gnt_q, last_gnt_d;
  logic [CH_W-1:0]     tag_mem_q [TAG_DEPTH];
  logic [CH_W-1:0]     tag_mem_d [TAG_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic [NUM_CH-1:0]   ch_ack_q, ch_ack_d;
  logic [DIN_W-1:0]    sink_data_q, sink_data_d;
  logic                sink_valid_q, sink_valid_d;
  logic [DOUT_W-1:0]   out_data_q, out_data_d;
  logic [CH_W-1:0]     out_ch_q, out_ch_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic [1:0]          err_q, err_d;

  logic [NUM_CH-1:0]   req_m;
  logic                gnt_found;
  logic [CH_W-1:0]     gnt_idx;
  logic [CH_W:0]       cand;
  logic [CH_W:0]       rr_nxt;
  logic                fifo_empty, fifo_full;
  logic                issue, pop;

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    last_vld_d   = 1'b0;
    last_gnt_d   = last_gnt_q;
    tag_mem_d    = tag_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    ch_ack_d     = '0;
    sink_data_d  = sink_data_q;
    sink_valid_d = 1'b0;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    out_valid_d  = 1'b0;
    err_d        = err_q;
    gnt_found    = 1'b0;
    gnt_idx      = '0;
    cand         = '0;
    rr_nxt       = '0;

    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == FULL_CNT);

    // The channel granted last edge may still show its old request.
    req_m = ch_req & ~(last_vld_q ? (ONE_HOT0 << last_gnt_q) : '0);

    for (int k = 0; k < NUM_CH; k++) begin
      cand = {1'b0, rr_q} + (CH_W+1)'(k);
      if (cand >= NUM_CH_W) begin
        cand = cand - NUM_CH_W;
      end else begin
        cand = cand;
      end
      if (!gnt_found && req_m[cand[CH_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[CH_W-1:0];
      end else begin
        gnt_found = gnt_found;
      end
    end

    issue = (state_q == RUN) && enable && gnt_found && !fifo_full;
    pop   = filt_source_valid && !fifo_empty;

    if (issue) begin
      rr_nxt                = {1'b0, gnt_idx} + (CH_W+1)'(1);
      rr_d                  = (rr_nxt == NUM_CH_W) ? '0 : rr_nxt[CH_W-1:0];
      last_vld_d            = 1'b1;
      last_gnt_d            = gnt_idx;
      ch_ack_d              = ONE_HOT0 << gnt_idx;
      sink_data_d           = ch_data[gnt_idx*DIN_W +: DIN_W];
      sink_valid_d          = 1'b1;
      tag_mem_d[wr_ptr_q]   = gnt_idx;
      wr_ptr_d              = wr_ptr_q + AW'(1);
    end else begin
      rr_d = rr_q;
    end

    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = filt_source_data;
      out_ch_d    = tag_mem_q[rd_ptr_q];
      rd_ptr_d    = rd_ptr_q + AW'(1);
    end else begin
      out_valid_d = 1'b0;
    end

    cnt_d = cnt_q + (AW+1)'(issue) - (AW+1)'(pop);

    if (filt_source_valid && fifo_empty) begin
      err_d[0] = 1'b1;
    end else begin
      err_d[0] = err_q[0];
    end
    if (filt_source_valid && (filt_source_error != 2'b00)) begin
      err_d[1] = 1'b1;
    end else begin
      err_d[1] = err_q[1];
    end

    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
        else        state_d = IDLE;
      end
      RUN: begin
        if (!enable) state_d = DRAIN;
        else         state_d = RUN;
      end
      DRAIN: begin
        if (enable)                             state_d = RUN;
        else if (fifo_empty && !out_valid_q)    state_d = IDLE;
        else                                    state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) || (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      last_vld_q   <= 1'b0;
      last_gnt_q   <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      ch_ack_q     <= '0;
      sink_data_q  <= '0;
      sink_valid_q <= 1'b0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 2'b00;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      last_vld_q   <= last_vld_d;
      last_gnt_q   <= last_gnt_d;
      tag_mem_q    <= tag_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      ch_ack_q     <= ch_ack_d;
      sink_data_q  <= sink_data_d;
      sink_valid_q <= sink_valid_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign ch_ack          = ch_ack_q;
  assign filt_sink_data  = sink_data_q;
  assign filt_sink_valid = sink_valid_q;
  assign filt_sink_error = 2'b00;
  assign out_data        = out_data_q;
  assign out_ch          = out_ch_q;
  assign out_valid       = out_valid_q;
  assign busy            = busy_q;
  assign err             = err_q;

endmodule
